// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
// Holds the FSM state encoding, the requester owner codes and the fetch byte mask.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  // Instruction fetches always read the low four bytes of the word
  localparam int FETCH_BYTES = 'h0F;

  // Wide enough for the largest legal starvation limit (15)
  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection between IFU and LSU with an LSU streak limit
// so a busy load/store unit cannot starve instruction fetch forever.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic if_valid,
  input  logic ls_valid,
  output logic if_grant,
  output logic ls_grant
);

  localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STARVE_MAX);

  logic [STREAK_W-1:0] streak;
  logic                starving;

  assign starving = if_valid && (streak == STREAK_LIM);

  always_comb begin
    if_grant = 1'b0;
    ls_grant = 1'b0;
    if (idle) begin
      if (ls_valid && !starving) begin
        ls_grant = 1'b1;
      end else if (if_valid) begin
        if_grant = 1'b1;
      end
    end
  end

  // Streak only counts LSU wins that actually made the IFU wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (if_grant) begin
      streak <= '0;
    end else if (ls_grant) begin
      if (!if_valid) begin
        streak <= '0;
      end else if (streak != STREAK_LIM) begin
        streak <= streak + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Single-outstanding memory arbiter: latches the granted request, presents it
// to memory, then routes the one response back to the requester that owns it.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_rsp_valid,
  output logic [XLEN-1:0]   if_rsp_data,

  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_wr,
  input  logic [XLEN/8-1:0] ls_bytes,
  input  logic [XLEN-1:0]   ls_addr,
  input  logic [XLEN-1:0]   ls_wdata,
  output logic              ls_rsp_valid,
  output logic [XLEN-1:0]   ls_rsp_data,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wr,
  output logic [XLEN/8-1:0] mem_bytes,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,

  output logic              busy
);

  localparam int BW = XLEN / 8;
  localparam logic [BW-1:0] FETCH_MASK = BW'(FETCH_BYTES);

  state_t            state;
  state_t            state_nxt;
  logic              own_q;
  logic              wr_q;
  logic [BW-1:0]     bytes_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              idle;
  logic              if_grant;
  logic              ls_grant;
  logic              rsp_fire;
  logic [XLEN-1:0]   rsp_data;

  // Gating with rst_n keeps the ready outputs low while reset is held
  assign idle = (state == IDLE) && rst_n;

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .rst_n    (rst_n),
    .idle     (idle),
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .if_grant (if_grant),
    .ls_grant (ls_grant)
  );

  assign if_req_ready = if_grant;
  assign ls_req_ready = ls_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A response seen in the same cycle as mem_req_ready is not consumed
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (if_grant || ls_grant) state_nxt = REQ;
      REQ:     if (mem_req_ready)        state_nxt = RESP;
      RESP:    if (mem_rsp_valid)        state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_q   <= OWN_IF;
      wr_q    <= 1'b0;
      bytes_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (ls_grant) begin
      own_q   <= OWN_LS;
      wr_q    <= ls_wr;
      bytes_q <= ls_bytes;
      addr_q  <= ls_addr;
      wdata_q <= ls_wdata;
    end else if (if_grant) begin
      own_q   <= OWN_IF;
      wr_q    <= 1'b0;
      bytes_q <= FETCH_MASK;
      addr_q  <= if_addr;
      wdata_q <= '0;
    end
  end

  always_comb begin
    rsp_fire     = (state == RESP) && mem_rsp_valid;
    rsp_data     = wr_q ? '0 : mem_rsp_data;
    if_rsp_valid = rsp_fire && (own_q == OWN_IF);
    ls_rsp_valid = rsp_fire && (own_q == OWN_LS);
    if_rsp_data  = if_rsp_valid ? rsp_data : '0;
    ls_rsp_data  = ls_rsp_valid ? rsp_data : '0;
  end

  assign mem_req_valid = (state == REQ);
  assign mem_wr        = wr_q;
  assign mem_bytes     = bytes_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mem_arb.sv
// Randomized bench for mem_arb: a transaction-level model predicts grants from
// the streak rule and the expected memory request / response for each one.
module tb_mem_arb;

  localparam int XLEN   = 64;
  localparam int BW     = XLEN / 8;
  localparam int STARVE = 4;

  logic            clk;
  logic            rst_n;
  logic            if_req_valid;
  logic            if_req_ready;
  logic [XLEN-1:0] if_addr;
  logic            if_rsp_valid;
  logic [XLEN-1:0] if_rsp_data;
  logic            ls_req_valid;
  logic            ls_req_ready;
  logic            ls_wr;
  logic [BW-1:0]   ls_bytes;
  logic [XLEN-1:0] ls_addr;
  logic [XLEN-1:0] ls_wdata;
  logic            ls_rsp_valid;
  logic [XLEN-1:0] ls_rsp_data;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_wr;
  logic [BW-1:0]   mem_bytes;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            busy;

  int errors   = 0;
  int checks   = 0;
  int streak_m = 0;

  mem_arb #(
    .XLEN       (XLEN),
    .STARVE_MAX (STARVE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_addr       (if_addr),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_data   (if_rsp_data),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_wr         (ls_wr),
    .ls_bytes      (ls_bytes),
    .ls_addr       (ls_addr),
    .ls_wdata      (ls_wdata),
    .ls_rsp_valid  (ls_rsp_valid),
    .ls_rsp_data   (ls_rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_wr        (mem_wr),
    .mem_bytes     (mem_bytes),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic scramble();
    if_req_valid = 1'($urandom % 2);
    ls_req_valid = 1'($urandom % 2);
    ls_wr        = 1'($urandom % 2);
    ls_bytes     = BW'($urandom);
    if_addr      = {$urandom, $urandom};
    ls_addr      = {$urandom, $urandom};
    ls_wdata     = {$urandom, $urandom};
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".busy"},          64'(busy),          64'd0);
    checkOutput({tag, ".if_req_ready"},  64'(if_req_ready),  64'd0);
    checkOutput({tag, ".ls_req_ready"},  64'(ls_req_ready),  64'd0);
    checkOutput({tag, ".mem_req_valid"}, 64'(mem_req_valid), 64'd0);
    checkOutput({tag, ".if_rsp_valid"},  64'(if_rsp_valid),  64'd0);
    checkOutput({tag, ".ls_rsp_valid"},  64'(ls_rsp_valid),  64'd0);
    checkOutput({tag, ".mem_addr"},      mem_addr,           64'd0);
    checkOutput({tag, ".mem_wdata"},     mem_wdata,          64'd0);
    checkOutput({tag, ".mem_bytes"},     64'(mem_bytes),     64'd0);
    checkOutput({tag, ".mem_wr"},        64'(mem_wr),        64'd0);
  endtask

  // One complete transaction from the IDLE grant to the routed response.
  task automatic applyStimulus(
    input  bit              iv,
    input  bit              lv,
    input  bit              lwr,
    input  logic [BW-1:0]   lb,
    input  logic [XLEN-1:0] ia,
    input  logic [XLEN-1:0] la,
    input  logic [XLEN-1:0] lw,
    input  int              req_wait,
    input  int              rsp_wait,
    input  logic [XLEN-1:0] rdata,
    input  bit              spur,
    output bit              saw_ls
  );
    bit              exp_ls, exp_if;
    bit              exp_wr;
    logic [BW-1:0]   exp_bytes;
    logic [XLEN-1:0] exp_addr, exp_wdata, exp_data;

    @(negedge clk);
    if_req_valid  = iv;
    ls_req_valid  = lv;
    ls_wr         = lwr;
    ls_bytes      = lb;
    if_addr       = ia;
    ls_addr       = la;
    ls_wdata      = lw;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;

    exp_ls = lv && !(iv && streak_m == STARVE);
    exp_if = iv && !exp_ls;
    saw_ls = ls_req_ready;
    checkOutput("idle.busy",         64'(busy),         64'd0);
    checkOutput("grant.ls_req_ready", 64'(ls_req_ready), 64'(exp_ls));
    checkOutput("grant.if_req_ready", 64'(if_req_ready), 64'(exp_if));

    if (exp_ls) begin
      exp_wr    = lwr;
      exp_bytes = lb;
      exp_addr  = la;
      exp_wdata = lw;
      streak_m  = iv ? ((streak_m < STARVE) ? streak_m + 1 : STARVE) : 0;
    end else begin
      exp_wr    = 1'b0;
      exp_bytes = BW'(8'h0F);
      exp_addr  = ia;
      exp_wdata = '0;
      streak_m  = 0;
    end
    exp_data = exp_wr ? '0 : rdata;

    @(negedge clk);
    scramble();
    #1;
    checkOutput("req.mem_req_valid", 64'(mem_req_valid), 64'd1);
    checkOutput("req.busy",          64'(busy),          64'd1);
    checkOutput("req.if_req_ready",  64'(if_req_ready),  64'd0);
    checkOutput("req.ls_req_ready",  64'(ls_req_ready),  64'd0);
    checkOutput("req.mem_wr",        64'(mem_wr),        64'(exp_wr));
    checkOutput("req.mem_bytes",     64'(mem_bytes),     64'(exp_bytes));
    checkOutput("req.mem_addr",      mem_addr,           exp_addr);
    checkOutput("req.mem_wdata",     mem_wdata,          exp_wdata);

    for (int i = 0; i < req_wait; i++) begin
      @(negedge clk);
      scramble();
      #1;
      checkOutput("hold.mem_req_valid", 64'(mem_req_valid), 64'd1);
      checkOutput("hold.mem_addr",      mem_addr,           exp_addr);
      checkOutput("hold.mem_wdata",     mem_wdata,          exp_wdata);
      checkOutput("hold.mem_bytes",     64'(mem_bytes),     64'(exp_bytes));
      checkOutput("hold.mem_wr",        64'(mem_wr),        64'(exp_wr));
    end

    mem_req_ready = 1'b1;
    mem_rsp_valid = spur;
    mem_rsp_data  = {$urandom, $urandom};
    #1;
    checkOutput("req.if_rsp_valid", 64'(if_rsp_valid), 64'd0);
    checkOutput("req.ls_rsp_valid", 64'(ls_rsp_valid), 64'd0);

    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    checkOutput("resp.mem_req_valid", 64'(mem_req_valid), 64'd0);
    checkOutput("resp.busy",          64'(busy),          64'd1);

    for (int i = 0; i < rsp_wait; i++) begin
      checkOutput("wait.if_rsp_valid", 64'(if_rsp_valid), 64'd0);
      checkOutput("wait.ls_rsp_valid", 64'(ls_rsp_valid), 64'd0);
      @(negedge clk);
      #1;
    end

    mem_rsp_valid = 1'b1;
    mem_rsp_data  = rdata;
    #1;
    if (exp_ls) begin
      checkOutput("rsp.ls_rsp_valid", 64'(ls_rsp_valid), 64'd1);
      checkOutput("rsp.ls_rsp_data",  ls_rsp_data,        exp_data);
      checkOutput("rsp.if_rsp_valid", 64'(if_rsp_valid), 64'd0);
    end else begin
      checkOutput("rsp.if_rsp_valid", 64'(if_rsp_valid), 64'd1);
      checkOutput("rsp.if_rsp_data",  if_rsp_data,        exp_data);
      checkOutput("rsp.ls_rsp_valid", 64'(ls_rsp_valid), 64'd0);
    end

    @(negedge clk);
    mem_rsp_valid = 1'b0;
    if_req_valid  = 1'b0;
    ls_req_valid  = 1'b0;
    #1;
    checkOutput("done.busy",         64'(busy),         64'd0);
    checkOutput("done.if_rsp_valid", 64'(if_rsp_valid), 64'd0);
    checkOutput("done.ls_rsp_valid", 64'(ls_rsp_valid), 64'd0);
  endtask

  initial begin
    bit              saw;
    bit              iv, lv, lwr, spur;
    bit              starve_order [7];
    logic [XLEN-1:0] rnd_ia, rnd_la, rnd_lw, rnd_rd;

    starve_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    rst_n         = 1'b0;
    if_req_valid  = 1'b1;
    ls_req_valid  = 1'b1;
    if_addr       = 64'h1234;
    ls_wr         = 1'b1;
    ls_bytes      = 8'hFF;
    ls_addr       = 64'h5678;
    ls_wdata      = 64'h9ABC;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hDEAD;
    #22;
    checkAllZero("reset");

    @(negedge clk);
    rst_n         = 1'b1;
    if_req_valid  = 1'b0;
    ls_req_valid  = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    streak_m      = 0;

    $display("[TB] spurious response in IDLE");
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hBAD;
    #1;
    checkOutput("spur.if_rsp_valid", 64'(if_rsp_valid), 64'd0);
    checkOutput("spur.ls_rsp_valid", 64'(ls_rsp_valid), 64'd0);
    checkOutput("spur.busy",         64'(busy),         64'd0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    checkOutput("spur.busy_after", 64'(busy), 64'd0);

    $display("[TB] IFU fetch alone");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 64'h8000_0000, 64'h0, 64'h0,
                  0, 2, 64'h13, 1'b0, saw);

    $display("[TB] IFU and LSU store together");
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF, 64'h4000, 64'h100, 64'h1122_3344_5566_7788,
                  0, 1, 64'hFEED, 1'b0, saw);
    checkOutput("both.ls_first", 64'(saw), 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 64'h4000, 64'h0, 64'h0,
                  0, 0, 64'h77, 1'b0, saw);
    checkOutput("both.if_second", 64'(saw), 64'd0);

    $display("[TB] starvation limit");
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h0F, 64'h2000 + 64'(k), 64'h3000 + 64'(k), 64'h0,
                    0, 0, 64'(k) + 64'h50, 1'b0, saw);
      checkOutput($sformatf("starve.order%0d", k), 64'(saw), 64'(starve_order[k]));
    end

    $display("[TB] long memory stall with same-cycle response");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h3C, 64'h0, 64'hA0A0, 64'hCAFE_F00D,
                  5, 1, 64'h99, 1'b1, saw);

    $display("[TB] reset while in RESP");
    @(negedge clk);
    ls_req_valid  = 1'b1;
    if_req_valid  = 1'b0;
    ls_wr         = 1'b0;
    ls_bytes      = 8'hF0;
    ls_addr       = 64'hBEEF;
    @(negedge clk);
    ls_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    if_req_valid  = 1'b1;
    ls_req_valid  = 1'b1;
    #1;
    checkOutput("rstresp.busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkAllZero("rstresp");
    @(negedge clk);
    rst_n         = 1'b1;
    if_req_valid  = 1'b0;
    ls_req_valid  = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h5555;
    streak_m      = 0;
    #1;
    checkOutput("late.if_rsp_valid", 64'(if_rsp_valid), 64'd0);
    checkOutput("late.ls_rsp_valid", 64'(ls_rsp_valid), 64'd0);
    checkOutput("late.busy",         64'(busy),         64'd0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    checkOutput("late.busy_after", 64'(busy), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h0F, 64'h0, 64'h600, 64'h0,
                  1, 1, 64'h4242, 1'b0, saw);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 40; n++) begin
      iv     = 1'($urandom % 2);
      lv     = 1'($urandom % 2);
      if (!iv && !lv) lv = 1'b1;
      lwr    = 1'($urandom % 2);
      spur   = 1'($urandom % 2);
      rnd_ia = {$urandom, $urandom};
      rnd_la = {$urandom, $urandom};
      rnd_lw = {$urandom, $urandom};
      rnd_rd = {$urandom, $urandom};
      applyStimulus(iv, lv, lwr, BW'($urandom), rnd_ia, rnd_la, rnd_lw,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    rnd_rd, spur, saw);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter XLEN, default 64, SHALL set the data/address width; 32 is also legal.
REQ-002 Parameter STARVE_MAX, default 4, SHALL set the maximum consecutive LSU grants while IFU waits; legal range 1..15.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 if_req_valid in 1 / if_req_ready out 1 / if_addr in XLEN SHALL form the fetch request port.
REQ-006 if_rsp_valid out 1 / if_rsp_data out XLEN SHALL form the fetch response port.
REQ-007 ls_req_valid in 1 / ls_req_ready out 1 / ls_wr in 1 / ls_bytes in XLEN/8 / ls_addr in XLEN / ls_wdata in XLEN SHALL form the load/store request port, carrying the acs_* semantics.
REQ-008 ls_rsp_valid out 1 / ls_rsp_data out XLEN SHALL form the load/store response port.
REQ-009 mem_req_valid out 1 / mem_req_ready in 1 / mem_wr out 1 / mem_bytes out XLEN/8 / mem_addr out XLEN / mem_wdata out XLEN SHALL form the shared memory request port.
REQ-010 mem_rsp_valid in 1 / mem_rsp_data in XLEN SHALL form the memory response port; memory returns exactly one response per request, writes included.
REQ-011 busy out 1 SHALL be high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, REQ and RESP; at most one transaction is outstanding.
REQ-013 In IDLE, exactly one of if_req_ready/ls_req_ready SHALL be high, combinationally, and only for the granted requester with valid high.
REQ-014 Grant priority: LSU wins when both are valid, unless streak == STARVE_MAX, in which case IFU wins.
REQ-015 streak SHALL increment on an LSU grant while if_req_valid is high, clear on any IFU grant, clear on an LSU grant with if_req_valid low, and saturate at STARVE_MAX.
REQ-016 On a handshake (valid & ready), the block SHALL latch owner, wr, bytes, addr and wdata, then move IDLE->REQ.
REQ-017 An IFU request SHALL latch wr=0 and bytes=0x0F, with wdata=0.
REQ-018 In REQ, mem_req_valid=1 and the mem_* fields SHALL hold the latched values, stable until mem_req_ready; on mem_req_ready the FSM moves REQ->RESP.
REQ-019 In RESP, mem_rsp_valid SHALL assert the owner's rsp_valid combinationally for that cycle, with rsp_data = mem_rsp_data (0 for writes); the FSM then moves RESP->IDLE.
REQ-020 Minimum latency: handshake in cycle N, mem_req_valid in N+1, next grant possible in the cycle after the response.
REQ-021 mem_rsp_valid outside RESP SHALL be ignored; the non-owner's rsp_valid SHALL never assert.
REQ-022 Requester fields sampled after a handshake SHALL have no effect on the transaction in flight.
REQ-023 mem_req_ready and mem_rsp_valid in the same cycle while in REQ SHALL only advance to RESP; the response is not consumed.

Reset
REQ-024 Asserting rst_n low SHALL immediately force IDLE, streak=0, and all latched fields to 0.
REQ-025 During reset all outputs SHALL be 0.
REQ-026 Reset mid-transaction SHALL drop the transaction; the memory model is reset in the same domain.
REQ-027 Deassertion SHALL be synchronised externally; the first grant can occur in the first post-reset cycle.

Structure
REQ-028 Package mem_arb_pkg SHALL hold the state enum, owner encoding (OWN_IF=0, OWN_LS=1) and the FETCH_BYTES constant.
REQ-029 Grant and streak logic SHALL live in sub-module mem_arb_prio; the FSM and latches stay in mem_arb.
REQ-030 The expected implementation size is 150-300 lines total.

Verification
REQ-031 IFU alone at addr 0x80000000, mem ready immediately, rsp 0x13 after 2 cycles -> mem_bytes=0x0F, mem_wr=0, if_rsp_valid one cycle with 0x13, ls_rsp_valid stays 0.
REQ-032 IFU and LSU valid together, LSU store addr 0x100 bytes 0xFF -> LSU granted first, ls_rsp_data=0, then IFU granted.
REQ-033 IFU held valid, LSU valid back-to-back for 6 requests, STARVE_MAX=4 -> grant order LS,LS,LS,LS,IF,LS,LS.
REQ-034 mem_req_ready held low for 5 cycles -> mem_addr/mem_wdata/mem_bytes stable all 5 cycles, while requester inputs change randomly.
REQ-035 rst_n pulsed low while in RESP -> outputs 0 the same cycle, state IDLE, a late mem_rsp_valid is ignored, and the next request completes normally.
REQ-036 Spurious mem_rsp_valid in IDLE -> no rsp_valid on either port and no state change.
